// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares the single mem bank port among NUM_REQ
// requesters (index 0 = input loader, 1..NUM_REQ-1 = freemachines).
// A requester may lock the grant to do a read-modify-write.
//
// state | meaning
// IDLE  | no owner; choose the next active requester at or after rr_ptr
// ISSUE | owner's enables and fields are driven onto mem until mem_ack
// DRAIN | enables low; wait for mem to go quiet, then keep, park or release grant
// HOLD  | locked owner is idle; grant parked until it re-requests or unlocks

`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 3
`endif
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 8
`endif

module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_write_en,
  input  logic [NUM_REQ-1:0]                   req_read_en,
  input  logic [NUM_REQ-1:0]                   req_lock,
  input  logic [NUM_REQ*`BANK_ADDR_WIDTH-1:0]  req_row_addr,
  input  logic [NUM_REQ*`COL_ADDR_WIDTH-1:0]   req_col_addr,
  input  logic [NUM_REQ*`TX_DATA_WIDTH-1:0]    req_partial_vec,
  output logic [NUM_REQ-1:0]                   req_ack,
  output logic [`TX_DATA_WIDTH-1:0]            req_partial_vec_out,
  output logic [NUM_REQ-1:0]                   grant_out,
  output logic                                 mem_write_en,
  output logic                                 mem_read_en,
  output logic [`BANK_ADDR_WIDTH-1:0]          mem_row_addr,
  output logic [`COL_ADDR_WIDTH-1:0]           mem_col_addr,
  output logic [`TX_DATA_WIDTH-1:0]            mem_partial_vec,
  input  logic                                 mem_ack,
  input  logic                                 mem_busy,
  input  logic [`TX_DATA_WIDTH-1:0]            mem_partial_vec_in
);

  localparam int BW = `BANK_ADDR_WIDTH;
  localparam int CW = `COL_ADDR_WIDTH;
  localparam int DW = `TX_DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]         state;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   g_idx;
  logic [IDX_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0] active;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  int                 cand;

  logic               sel_write;
  logic               sel_read;
  logic [BW-1:0]      sel_row;
  logic [CW-1:0]      sel_col;
  logic [DW-1:0]      sel_data;

  logic               g_lock;
  logic               g_active;
  logic               issuing;
  logic [IDX_W-1:0]   next_ptr;

  assign active   = req_write_en | req_read_en;
  assign g_lock   = |(req_lock & grant);
  assign g_active = |(active & grant);
  assign issuing  = (state == ST_ISSUE);
  assign next_ptr = (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

  // Round-robin search: first active requester starting at rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && active[cand]) begin
        pick_found    = 1'b1;
        pick_idx      = IDX_W'(cand);
        pick_oh[cand] = 1'b1;
      end
    end
  end

  // AND-OR mux of the owner's request fields, keyed by the one-hot grant.
  always_comb begin
    sel_write = 1'b0;
    sel_read  = 1'b0;
    sel_row   = '0;
    sel_col   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_write = sel_write | req_write_en[i];
        sel_read  = sel_read  | req_read_en[i];
        sel_row   = sel_row   | req_row_addr[i*BW +: BW];
        sel_col   = sel_col   | req_col_addr[i*CW +: CW];
        sel_data  = sel_data  | req_partial_vec[i*DW +: DW];
      end
    end
  end

  // Mem bus is driven only while issuing; write wins when both enables are set.
  always_comb begin
    mem_write_en    = issuing & sel_write;
    mem_read_en     = issuing & sel_read & ~sel_write;
    mem_row_addr    = issuing ? sel_row  : '0;
    mem_col_addr    = issuing ? sel_col  : '0;
    mem_partial_vec = issuing ? sel_data : '0;
  end

  assign req_ack             = grant & {NUM_REQ{mem_ack}};
  assign req_partial_vec_out = mem_partial_vec_in;
  assign grant_out           = grant;

  // Arbitration FSM; grant only moves in IDLE, DRAIN or HOLD with mem idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      grant  <= '0;
      g_idx  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!mem_busy && pick_found) begin
            grant <= pick_oh;
            g_idx <= pick_idx;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ack) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!mem_busy && !mem_ack) begin
            if (g_lock && g_active) begin
              state <= ST_ISSUE;
            end else if (g_lock) begin
              state <= ST_HOLD;
            end else begin
              rr_ptr <= next_ptr;
              grant  <= '0;
              state  <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (g_active && !mem_busy) begin
            state <= ST_ISSUE;
          end else if (!g_lock) begin
            rr_ptr <= next_ptr;
            grant  <= '0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays the mem model by
// driving mem_ack / mem_busy by hand.

`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 3
`endif
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 8
`endif

module tb_mem_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int BW = `BANK_ADDR_WIDTH;
  localparam int CW = `COL_ADDR_WIDTH;
  localparam int DW = `TX_DATA_WIDTH;

  logic                  clock;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_write_en;
  logic [NUM_REQ-1:0]    req_read_en;
  logic [NUM_REQ-1:0]    req_lock;
  logic [NUM_REQ*BW-1:0] req_row_addr;
  logic [NUM_REQ*CW-1:0] req_col_addr;
  logic [NUM_REQ*DW-1:0] req_partial_vec;
  logic [NUM_REQ-1:0]    req_ack;
  logic [DW-1:0]         req_partial_vec_out;
  logic [NUM_REQ-1:0]    grant_out;
  logic                  mem_write_en;
  logic                  mem_read_en;
  logic [BW-1:0]         mem_row_addr;
  logic [CW-1:0]         mem_col_addr;
  logic [DW-1:0]         mem_partial_vec;
  logic                  mem_ack;
  logic                  mem_busy;
  logic [DW-1:0]         mem_partial_vec_in;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clock               (clock),
    .reset               (reset),
    .req_write_en        (req_write_en),
    .req_read_en         (req_read_en),
    .req_lock            (req_lock),
    .req_row_addr        (req_row_addr),
    .req_col_addr        (req_col_addr),
    .req_partial_vec     (req_partial_vec),
    .req_ack             (req_ack),
    .req_partial_vec_out (req_partial_vec_out),
    .grant_out           (grant_out),
    .mem_write_en        (mem_write_en),
    .mem_read_en         (mem_read_en),
    .mem_row_addr        (mem_row_addr),
    .mem_col_addr        (mem_col_addr),
    .mem_partial_vec     (mem_partial_vec),
    .mem_ack             (mem_ack),
    .mem_busy            (mem_busy),
    .mem_partial_vec_in  (mem_partial_vec_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic re, input logic lk,
                         input logic [BW-1:0] row, input logic [CW-1:0] col,
                         input logic [DW-1:0] data);
    req_write_en[i] = we;
    req_read_en[i]  = re;
    req_lock[i]     = lk;
    req_row_addr[i*BW +: BW]    = row;
    req_col_addr[i*CW +: CW]    = col;
    req_partial_vec[i*DW +: DW] = data;
  endtask

  task automatic clr_req(input int i);
    set_req(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Called with the arbiter in ISSUE for requester idx; completes the
  // transaction and leaves two more cycles so IDLE can re-grant.
  task automatic serve(input int idx, input logic exp_we, input logic exp_re, input string tag);
    chk({tag, "_grant"}, grant_out, 32'(1) << idx);
    chk({tag, "_we"}, mem_write_en, exp_we);
    chk({tag, "_re"}, mem_read_en, exp_re);
    mem_ack = 1'b1;
    #1;
    chk({tag, "_ack"}, req_ack, 32'(1) << idx);
    tick();
    clr_req(idx);
    mem_ack = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req_write_en = '0;
    req_read_en = '0;
    req_lock = '0;
    req_row_addr = '0;
    req_col_addr = '0;
    req_partial_vec = '0;
    mem_ack = 1'b0;
    mem_busy = 1'b0;
    mem_partial_vec_in = 8'h96;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_grant", grant_out, 0);
    chk("rst_we", mem_write_en, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_row", mem_row_addr, 0);
    reset = 1'b0;

    // single write from the loader
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd3, 3'd0, 8'hA5);
    #1;
    chk("t1_pre_we", mem_write_en, 0);
    tick();
    chk("t1_we", mem_write_en, 1);
    chk("t1_re", mem_read_en, 0);
    chk("t1_row", mem_row_addr, 3);
    chk("t1_col", mem_col_addr, 0);
    chk("t1_data", mem_partial_vec, 8'hA5);
    chk("t1_grant", grant_out, 4'b0001);
    chk("t1_rdata", req_partial_vec_out, 8'h96);
    mem_ack = 1'b1;
    #1;
    chk("t1_ack", req_ack, 4'b0001);
    tick();
    clr_req(0);
    mem_ack = 1'b0;
    #1;
    chk("t1_drain_we", mem_write_en, 0);
    chk("t1_drain_ack", req_ack, 0);
    tick();
    chk("t1_idle_grant", grant_out, 0);

    // reset pulse so contention starts from rr_ptr=0
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;

    // contention: all four read -> 0,1,2,3 then 1,3
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b1, 1'b0, BW'(i + 8), CW'(i), 8'h00);
    #1;
    tick();
    serve(0, 1'b0, 1'b1, "t2_r0");
    serve(1, 1'b0, 1'b1, "t2_r1");
    serve(2, 1'b0, 1'b1, "t2_r2");
    serve(3, 1'b0, 1'b1, "t2_r3");
    chk("t2_idle_grant", grant_out, 0);
    set_req(1, 1'b0, 1'b1, 1'b0, 4'd1, 3'd1, 8'h00);
    set_req(3, 1'b0, 1'b1, 1'b0, 4'd3, 3'd3, 8'h00);
    #1;
    tick();
    serve(1, 1'b0, 1'b1, "t2_s1");
    serve(3, 1'b0, 1'b1, "t2_s3");

    // both enables high counts as a write; leaves rr_ptr=2
    set_req(1, 1'b1, 1'b1, 1'b0, 4'd6, 3'd2, 8'h11);
    #1;
    tick();
    serve(1, 1'b1, 1'b0, "t5_both");

    // locked read-modify-write by requester 2 while requester 1 waits
    set_req(2, 1'b0, 1'b1, 1'b1, 4'd5, 3'd2, 8'h00);
    set_req(1, 1'b0, 1'b1, 1'b0, 4'd1, 3'd1, 8'h00);
    #1;
    tick();
    chk("t3_rd_grant", grant_out, 4'b0100);
    chk("t3_rd_re", mem_read_en, 1);
    chk("t3_rd_row", mem_row_addr, 5);
    mem_ack = 1'b1;
    #1;
    chk("t3_rd_ack", req_ack, 4'b0100);
    tick();
    set_req(2, 1'b0, 1'b0, 1'b1, 4'd5, 3'd2, 8'h00);
    mem_ack = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("t3_hold_grant", grant_out, 4'b0100);
      chk("t3_hold_en", {mem_write_en, mem_read_en}, 2'b00);
      tick();
    end
    set_req(2, 1'b1, 1'b0, 1'b0, 4'd5, 3'd2, 8'h3C);
    #1;
    chk("t3_hold_we", mem_write_en, 0);
    tick();
    chk("t3_wr_grant", grant_out, 4'b0100);
    chk("t3_wr_we", mem_write_en, 1);
    chk("t3_wr_row", mem_row_addr, 5);
    chk("t3_wr_data", mem_partial_vec, 8'h3C);
    mem_ack = 1'b1;
    #1;
    chk("t3_wr_ack", req_ack, 4'b0100);
    tick();
    clr_req(2);
    mem_ack = 1'b0;
    tick();
    tick();
    serve(1, 1'b0, 1'b1, "t3_next");

    // busy gating after ack; rr_ptr=2 so requester 0 wins first
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd2, 3'd4, 8'h77);
    #1;
    tick();
    chk("t4_grant", grant_out, 4'b0001);
    chk("t4_we", mem_write_en, 1);
    mem_ack = 1'b1;
    mem_busy = 1'b1;
    tick();
    clr_req(0);
    mem_ack = 1'b0;
    set_req(3, 1'b0, 1'b1, 1'b0, 4'd9, 3'd1, 8'h00);
    #1;
    for (int c = 0; c < 6; c++) begin
      chk("t4_busy_grant", grant_out, 4'b0001);
      chk("t4_busy_en", {mem_write_en, mem_read_en}, 2'b00);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    tick();
    chk("t4_rel_grant", grant_out, 0);
    tick();
    serve(3, 1'b0, 1'b1, "t4_next");

    // async reset mid-ISSUE; move rr_ptr to 3 first so its reset is visible
    set_req(2, 1'b0, 1'b1, 1'b0, 4'd4, 3'd4, 8'h00);
    #1;
    tick();
    serve(2, 1'b0, 1'b1, "t6_pre");
    set_req(3, 1'b1, 1'b0, 1'b0, 4'd7, 3'd5, 8'h5A);
    #1;
    tick();
    chk("t6_issue_we", mem_write_en, 1);
    mem_ack = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_grant", grant_out, 0);
    chk("t6_rst_we", mem_write_en, 0);
    chk("t6_rst_row", mem_row_addr, 0);
    chk("t6_rst_data", mem_partial_vec, 0);
    chk("t6_rst_ack", req_ack, 0);
    mem_ack = 1'b0;
    clr_req(3);
    #2;
    reset = 1'b0;
    set_req(0, 1'b0, 1'b1, 1'b0, 4'd1, 3'd1, 8'h00);
    set_req(3, 1'b0, 1'b1, 1'b0, 4'd2, 3'd2, 8'h00);
    #1;
    tick();
    chk("t6_ptr_grant", grant_out, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
